vga_controller: RTL and testbench



---
 rtl/vga_pkg.sv | 94 +++++++++
 rtl/vga_timing.sv | 59 +++++
 rtl/vga_controller.sv | 112 +++++++++++
 tb/tb_vga_controller.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared constants and helpers for the VGA score display.
// Holds the 640x480@60 timing, the colour palette, the digit cell placement,
// the seven-segment rectangle geometry and the digit/segment helper functions.
package vga_pkg;

  // Horizontal timing, in pixel clocks
  localparam logic [9:0] H_VIS        = 10'd640;
  localparam logic [9:0] H_FP         = 10'd16;
  localparam logic [9:0] H_SYNC       = 10'd96;
  localparam logic [9:0] H_BP         = 10'd48;
  localparam logic [9:0] H_TOTAL      = H_VIS + H_FP + H_SYNC + H_BP;
  localparam logic [9:0] H_SYNC_FIRST = H_VIS + H_FP;
  localparam logic [9:0] H_SYNC_LAST  = H_SYNC_FIRST + H_SYNC - 10'd1;

  // Vertical timing, in lines
  localparam logic [9:0] V_VIS        = 10'd480;
  localparam logic [9:0] V_FP         = 10'd10;
  localparam logic [9:0] V_SYNC       = 10'd2;
  localparam logic [9:0] V_BP         = 10'd33;
  localparam logic [9:0] V_TOTAL      = V_VIS + V_FP + V_SYNC + V_BP;
  localparam logic [9:0] V_SYNC_FIRST = V_VIS + V_FP;
  localparam logic [9:0] V_SYNC_LAST  = V_SYNC_FIRST + V_SYNC - 10'd1;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb_t;

  localparam rgb_t RGB_BLANK  = 12'h000;
  localparam rgb_t RGB_LIT    = 12'hFFF;
  localparam rgb_t RGB_INGAME = 12'h004;
  localparam rgb_t RGB_OVER   = 12'h400;

  // Digit cells: 64 wide, 128 tall
  localparam logic [9:0] TENS_X0  = 10'd256;
  localparam logic [9:0] ONES_X0  = 10'd336;
  localparam logic [9:0] DIGIT_Y0 = 10'd176;
  localparam logic [9:0] DIGIT_W  = 10'd64;
  localparam logic [9:0] DIGIT_H  = 10'd128;

  // Segment rectangles inside a cell, index 0..6 = a..g, bounds inclusive
  localparam logic [9:0] SEG_X0 [7] = '{10'd0,  10'd48, 10'd48,  10'd0,   10'd0,   10'd0,  10'd0};
  localparam logic [9:0] SEG_X1 [7] = '{10'd63, 10'd63, 10'd63,  10'd63,  10'd15,  10'd15, 10'd63};
  localparam logic [9:0] SEG_Y0 [7] = '{10'd0,  10'd0,  10'd64,  10'd112, 10'd64,  10'd0,  10'd56};
  localparam logic [9:0] SEG_Y1 [7] = '{10'd15, 10'd63, 10'd127, 10'd127, 10'd127, 10'd63, 10'd71};

  // Segment mask for a decimal digit, bit order {g,f,e,d,c,b,a}
  function automatic logic [6:0] digit_segments(input logic [3:0] d);
    logic [6:0] m;
    case (d)
      4'd0:    m = 7'h3F;
      4'd1:    m = 7'h06;
      4'd2:    m = 7'h5B;
      4'd3:    m = 7'h4F;
      4'd4:    m = 7'h66;
      4'd5:    m = 7'h6D;
      4'd6:    m = 7'h7D;
      4'd7:    m = 7'h07;
      4'd8:    m = 7'h7F;
      4'd9:    m = 7'h6F;
      default: m = 7'h00;
    endcase
    return m;
  endfunction

  // Which segment rectangles contain cell offset (dx,dy); caller bounds the cell
  function automatic logic [6:0] seg_cover(input logic [9:0] dx, input logic [9:0] dy);
    logic [6:0] hit;
    for (int s = 0; s < 7; s++) begin
      hit[s] = (dx >= SEG_X0[s]) && (dx <= SEG_X1[s]) &&
               (dy >= SEG_Y0[s]) && (dy <= SEG_Y1[s]);
    end
    return hit;
  endfunction

  // Two decimal digits can only show 0..99
  function automatic logic [6:0] clamp99(input logic [31:0] s);
    return (s > 32'd99) ? 7'd99 : s[6:0];
  endfunction

  // Returns {tens, ones} for a value 0..99 using compares instead of a divider
  function automatic logic [7:0] split_digits(input logic [6:0] c);
    logic [3:0] tens;
    logic [3:0] ones;
    tens = 4'd0;
    for (int i = 1; i < 10; i++) begin
      if (c >= 7'(i * 10)) tens = 4'(i);
    end
    ones = 4'(c - 7'(tens * 4'd10));
    return {tens, ones};
  endfunction

endpackage

// File: rtl/vga_timing.sv
// 640x480@60 raster timing generator.
// Ports:
//   clk       pixel clock (25 MHz)
//   reset     asynchronous active-low reset
//   h_o/v_o   current horizontal / vertical counter values
//   visible_o counters are inside the 640x480 active area
//   hsync_o   registered horizontal sync, active low
//   vsync_o   registered vertical sync, active low
module vga_timing
  import vga_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  output logic [9:0] h_o,
  output logic [9:0] v_o,
  output logic       visible_o,
  output logic       hsync_o,
  output logic       vsync_o
);

  logic [9:0] h_q, h_d;
  logic [9:0] v_q, v_d;
  logic       hsync_q, hsync_d;
  logic       vsync_q, vsync_d;

  always_comb begin
    h_d = h_q + 10'd1;
    v_d = v_q;
    if (h_q == H_TOTAL - 10'd1) begin
      h_d = '0;
      v_d = (v_q == V_TOTAL - 10'd1) ? '0 : v_q + 10'd1;
    end
    // Sync is decoded from the current count and registered, so it lands
    // on the same edge as the colour register in the top level.
    hsync_d = !((h_q >= H_SYNC_FIRST) && (h_q <= H_SYNC_LAST));
    vsync_d = !((v_q >= V_SYNC_FIRST) && (v_q <= V_SYNC_LAST));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      h_q     <= '0;
      v_q     <= '0;
      hsync_q <= 1'b1;
      vsync_q <= 1'b1;
    end else begin
      h_q     <= h_d;
      v_q     <= v_d;
      hsync_q <= hsync_d;
      vsync_q <= vsync_d;
    end
  end

  assign h_o       = h_q;
  assign v_o       = v_q;
  assign visible_o = (h_q < H_VIS) && (v_q < V_VIS);
  assign hsync_o   = hsync_q;
  assign vsync_o   = vsync_q;

endmodule

// File: rtl/vga_controller.sv
// VGA back end for the reaction-button game: 640x480@60 timing plus the
// score drawn as two 64x128 seven-segment digits over a state-coloured
// background.
// Ports (positional order):
//   ingame          1 = game running (blue background), 0 = red background
//   score[31:0]     unsigned score, shown saturated at 99
//   clk             25 MHz pixel clock
//   reset           asynchronous active-low reset
//   hSync, vSync    active-low sync
//   VGA_R/G/B[3:0]  colour
//   ps2_clk/data    reserved keyboard lines, never driven
module vga_controller
  import vga_pkg::*;
(
  input  logic        ingame,
  input  logic [31:0] score,
  input  logic        clk,
  input  logic        reset,
  output logic        hSync,
  output logic        vSync,
  output logic [3:0]  VGA_R,
  output logic [3:0]  VGA_G,
  output logic [3:0]  VGA_B,
  inout  wire         ps2_clk,
  inout  wire         ps2_data
);

  logic [9:0] h;
  logic [9:0] v;
  logic       visible;

  vga_timing u_timing (
    .clk       (clk),
    .reset     (reset),
    .h_o       (h),
    .v_o       (v),
    .visible_o (visible),
    .hsync_o   (hSync),
    .vsync_o   (vSync)
  );

  // Frame latch: sampled once per frame at the start of vertical blank so a
  // score change mid-frame never splits the picture.
  logic        ingame_q, ingame_d;
  logic [31:0] score_q,  score_d;

  always_comb begin
    ingame_d = ingame_q;
    score_d  = score_q;
    if ((h == 10'd0) && (v == V_VIS)) begin
      ingame_d = ingame;
      score_d  = score;
    end
  end

  logic [6:0] clamped;
  logic [3:0] tens;
  logic [3:0] ones;
  logic [6:0] tens_mask;
  logic [6:0] ones_mask;

  assign clamped      = clamp99(score_q);
  assign {tens, ones} = split_digits(clamped);
  assign tens_mask    = (clamped < 7'd10) ? 7'h00 : digit_segments(tens);
  assign ones_mask    = digit_segments(ones);

  // Offsets wrap to large values left of / above a cell, so one unsigned
  // upper-bound compare per axis doubles as the in-cell test.
  logic [9:0] tens_dx;
  logic [9:0] ones_dx;
  logic [9:0] cell_dy;
  logic       in_tens;
  logic       in_ones;
  logic       lit;

  assign tens_dx = h - TENS_X0;
  assign ones_dx = h - ONES_X0;
  assign cell_dy = v - DIGIT_Y0;
  assign in_tens = (tens_dx < DIGIT_W) && (cell_dy < DIGIT_H);
  assign in_ones = (ones_dx < DIGIT_W) && (cell_dy < DIGIT_H);
  assign lit     = (in_tens && |(seg_cover(tens_dx, cell_dy) & tens_mask)) ||
                   (in_ones && |(seg_cover(ones_dx, cell_dy) & ones_mask));

  rgb_t rgb_q, rgb_d;

  always_comb begin
    if (!visible)      rgb_d = RGB_BLANK;
    else if (lit)      rgb_d = RGB_LIT;
    else if (ingame_q) rgb_d = RGB_INGAME;
    else               rgb_d = RGB_OVER;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ingame_q <= 1'b0;
      score_q  <= '0;
      rgb_q    <= RGB_BLANK;
    end else begin
      ingame_q <= ingame_d;
      score_q  <= score_d;
      rgb_q    <= rgb_d;
    end
  end

  assign VGA_R = rgb_q.r;
  assign VGA_G = rgb_q.g;
  assign VGA_B = rgb_q.b;

  assign ps2_clk  = 1'bz;
  assign ps2_data = 1'bz;

endmodule

// File: tb/tb_vga_controller.sv
module tb_vga_controller;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        ingame = 1'b0;
  logic [31:0] score = '0;
  logic        hSync, vSync;
  logic [3:0]  VGA_R, VGA_G, VGA_B;
  wire         ps2_clk, ps2_data;

  vga_controller dut (
    .ingame   (ingame),
    .score    (score),
    .clk      (clk),
    .reset    (reset),
    .hSync    (hSync),
    .vSync    (vSync),
    .VGA_R    (VGA_R),
    .VGA_G    (VGA_G),
    .VGA_B    (VGA_B),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data)
  );

  always #20 clk = ~clk;

  typedef struct {
    int          h;
    int          v;
    logic [13:0] val;   // {hSync, vSync, R, G, B}
  } exp_t;

  exp_t expq[$];
  int   errors = 0;
  int   checks = 0;

  // Reference model state: raster position and latched game state
  int          mh = 0;
  int          mv = 0;
  logic        m_ing = 1'b0;
  logic [31:0] m_score = '0;
  int          jump_id = 0;
  int          jump_seen = 0;
  int          jump_val = 0;
  logic [9:0]  jv = '0;

  string SEGS [10] = '{"abcdef", "bc", "abdeg", "abcdg", "bcfg",
                       "acdfg", "acdefg", "abc", "abcdefg", "abcdfg"};

  function automatic bit in_rect(byte seg, int dx, int dy);
    case (seg)
      "a": return dy <= 15;
      "b": return dx >= 48 && dy <= 63;
      "c": return dx >= 48 && dy >= 64;
      "d": return dy >= 112;
      "e": return dx <= 15 && dy >= 64;
      "f": return dx <= 15 && dy <= 63;
      "g": return dy >= 56 && dy <= 71;
      default: return 1'b0;
    endcase
  endfunction

  function automatic bit digit_lit(int dx, int dy, int d);
    string s;
    if (dx < 0 || dx > 63 || dy < 0 || dy > 127) return 1'b0;
    s = SEGS[d];
    for (int i = 0; i < s.len(); i++)
      if (in_rect(s[i], dx, dy)) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [11:0] pix_ref(int h, int v, logic ing, logic [31:0] s);
    int c;
    if (h >= 640 || v >= 480) return 12'h000;
    c = (s > 32'd99) ? 99 : int'(s);
    if ((c >= 10 && digit_lit(h - 256, v - 176, c / 10)) ||
        digit_lit(h - 336, v - 176, c % 10))
      return 12'hFFF;
    return ing ? 12'h004 : 12'h400;
  endfunction

  // Model: each rising edge, predict what the output registers capture
  initial forever begin
    exp_t e;
    @(posedge clk);
    if (!reset) begin
      e.h = -1; e.v = -1; e.val = {1'b1, 1'b1, 12'h000};
      expq.push_back(e);
      mh = 0; mv = 0; m_ing = 1'b0; m_score = '0;
    end else begin
      if (jump_id != jump_seen) begin
        mv = jump_val;
        jump_seen = jump_id;
      end
      e.h = mh; e.v = mv;
      e.val = {!(mh >= 656 && mh <= 751), !(mv >= 490 && mv <= 491),
               pix_ref(mh, mv, m_ing, m_score)};
      expq.push_back(e);
      if (mh == 0 && mv == 480) begin
        m_ing = ingame;
        m_score = score;
      end
      mh++;
      if (mh == 800) begin
        mh = 0;
        mv++;
        if (mv == 525) mv = 0;
      end
    end
  end

  // Monitor: every falling edge, compare registered outputs with prediction
  initial forever begin
    exp_t        e;
    logic [13:0] got;
    @(negedge clk);
    if (expq.size() > 0) begin
      e = expq.pop_front();
      got = {hSync, vSync, VGA_R, VGA_G, VGA_B};
      checks++;
      if (got !== e.val) begin
        errors++;
        $display("FAIL pixel h=%0d v=%0d got=%h want=%h", e.h, e.v, got, e.val);
      end
    end
  end

  task automatic run_cycles(int n);
    repeat (n) @(negedge clk);
  endtask

  // Move the raster to line 'target' early in a line (no wrap while held)
  task automatic jump_v(int target);
    int k;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (mh != 10 && k < 1000);
    if (k >= 1000) begin
      errors++;
      checks++;
      $display("FAIL jump_timeout h=%0d want=10", mh);
    end
    #5;
    jv = 10'(target);
    force dut.u_timing.v_q = jv;
    jump_val = target;
    jump_id++;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    #5;
    release dut.u_timing.v_q;
  endtask

  task automatic set_inputs(logic ing, logic [31:0] s);
    @(negedge clk);
    #5;
    ingame = ing;
    score  = s;
  endtask

  task automatic visit_rows();
    jump_v(180);
    jump_v(240);
    jump_v(300);
    jump_v($urandom_range(170, 310));
    run_cycles(800);
  endtask

  logic        st_ing [6];
  logic [31:0] st_score [6];

  initial begin
    st_ing[0] = 1'b1; st_score[0] = 32'd12;
    st_ing[1] = 1'b0; st_score[1] = 32'd5;
    st_ing[2] = 1'b1; st_score[2] = 32'hFFFF_FFFF;
    st_ing[3] = 1'b1; st_score[3] = 32'd3;
    st_ing[4] = 1'b1; st_score[4] = 32'd8;
    st_ing[5] = 1'($urandom_range(0, 1));
    st_score[5] = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 120));

    reset = 1'b0;
    run_cycles(10);
    #5 reset = 1'b1;

    // Two full lines: hSync pulse width and line period
    run_cycles(1600);

    // Vertical sync region, skipping the latch line
    jump_v(486);
    run_cycles(8 * 800);

    for (int i = 0; i < 6; i++) begin
      // Change inputs mid-frame; the current picture must not change
      jump_v(100);
      set_inputs(st_ing[i], st_score[i]);
      jump_v(240);
      jump_v($urandom_range(170, 310));
      // Pass the latch point at h=0, v=480
      jump_v(478);
      run_cycles(800);
      jump_v(524);
      visit_rows();
    end

    // Reset in the middle of a frame, then restart
    jump_v(200);
    @(negedge clk);
    #5 reset = 1'b0;
    run_cycles(5);
    #5 reset = 1'b1;
    run_cycles(1000);

    @(negedge clk);
    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #20ms;
    $display("FAIL watchdog time_limit reached");
    $fatal(1, "watchdog");
  end

endmodule
